lcd_text_buffer: RTL
====================

LCD_TEXT_BUFFER -- requirements
Module: lcd_text_buffer

Interface
REQ-001 Parameter COLS, default 16, characters per display row (1..64).
REQ-002 Parameter ROWS, default 2, display rows (1..4); N = COLS*ROWS cells, N >= 2.
REQ-003 Parameter BLANK, default 8'h20, fill character for reset, clear and backspace.
REQ-004 Parameter AUTO_ADV, default 1; 1 = cursor advances after each write, 0 = cursor holds.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 next_i  in  1  asynchronous button level; each rising edge = cursor +1.
REQ-008 prev_i  in  1  asynchronous button level; each rising edge = cursor -1.
REQ-009 wr_i  in  1  synchronous one-cycle strobe; write char_i at cursor.
REQ-010 char_i  in  8  ASCII code to write.
REQ-011 bksp_i  in  1  synchronous one-cycle strobe; backspace.
REQ-012 clr_i  in  1  synchronous one-cycle strobe; clear whole buffer.
REQ-013 symbols_o  out  8*N  flattened buffer; cell 0 in bits [8N-1:8N-8], cell N-1 in bits [7:0].
REQ-014 cursor_o  out  $clog2(N)  current cell index.
REQ-015 busy_o  out  1  high while clear sweep in progress.

Function
REQ-016 next_i/prev_i SHALL each pass through a 2-flop synchronizer plus edge-detect register; rising edge yields one-cycle step pulse.
REQ-017 Step pulse SHALL update cursor_o at the 3rd rising clk edge after the input is first sampled high; held level SHALL produce exactly one step.
REQ-018 Cursor arithmetic SHALL wrap modulo N: N-1 +1 -> 0, 0 -1 -> N-1 (also for non-power-of-2 N).
REQ-019 Simultaneous next and prev step pulses in same cycle SHALL leave cursor unchanged.
REQ-020 FSM states: IDLE, CLEAR; IDLE -> CLEAR on clr_i; CLEAR -> IDLE after cell N-1 is written.
REQ-021 In IDLE, command priority per cycle SHALL be clr_i > wr_i > bksp_i > step pulse; lower-priority events in that cycle are dropped.
REQ-022 wr_i in IDLE SHALL store char_i into cell[cursor]; visible on symbols_o the next cycle; if AUTO_ADV=1 cursor advances by 1 (wrapping) in the same edge.
REQ-023 bksp_i in IDLE SHALL set cursor to cursor-1 (wrapping) and store BLANK in that new cell in the same edge.
REQ-024 CLEAR SHALL write BLANK to one cell per cycle, index 0 to N-1, taking exactly N cycles; busy_o high for exactly those N cycles starting the cycle after clr_i.
REQ-025 On CLEAR -> IDLE, cursor_o SHALL be 0 and busy_o low.
REQ-026 While busy_o=1, wr_i, bksp_i, clr_i and step pulses SHALL be ignored and not queued; synchronizers keep running so held buttons produce no step on exit.
REQ-027 symbols_o and cursor_o SHALL be registered outputs with no combinational path from any input.
REQ-028 char_i values SHALL be stored unmodified (no ASCII filtering).

Reset
REQ-029 rst low SHALL immediately set all cells to BLANK, cursor_o=0, busy_o=0, FSM=IDLE, synchronizer and edge registers to 0, including mid-CLEAR.
REQ-030 After rst release, first command SHALL be accepted on the first rising clk edge with rst high.

Verification (COLS=16, ROWS=2, N=32, BLANK=8'h20, AUTO_ADV=1)
REQ-031 Reset then idle -> symbols_o = 32 x 8'h20, cursor_o=0, busy_o=0.
REQ-032 wr_i with char_i=8'h41, then 8'h42 -> cells 0,1 = 'A','B', cursor_o=2; bksp_i -> cell 1 = 8'h20, cursor_o=1.
REQ-033 prev_i pulse at cursor 0 -> cursor_o=31 after 3 clocks; next_i held high 10 cycles -> single step to 0; next_i and prev_i raised same cycle -> cursor unchanged.
REQ-034 Cursor 31, wr_i char_i=8'h5A -> cell 31 (symbols_o[7:0]) = 8'h5A, cursor_o=0.
REQ-035 Fill cells, clr_i -> busy_o high exactly 32 cycles, wr_i during sweep ignored, end: all 8'h20, cursor_o=0.
REQ-036 rst low at sweep cycle 10 -> all cells 8'h20, busy_o=0 immediately; wr_i after release accepted.

Source files
------------

// File: rtl/lcd_text_buffer.sv
// ============================================================================
// Module   : lcd_text_buffer
// Brief    : Character buffer for a COLS x ROWS text LCD. It has a cursor,
//            synchronized step buttons and a one-cell-per-cycle clear sweep.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lcd_text_buffer #(
  parameter int         COLS     = 16,
  parameter int         ROWS     = 2,
  parameter logic [7:0] BLANK    = 8'h20,
  parameter int         AUTO_ADV = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             next_i,
  input  logic                             prev_i,
  input  logic                             wr_i,
  input  logic [7:0]                       char_i,
  input  logic                             bksp_i,
  input  logic                             clr_i,
  output logic [8*COLS*ROWS-1:0]           symbols_o,
  output logic [$clog2(COLS*ROWS)-1:0]     cursor_o,
  output logic                             busy_o
);

  localparam int            c_n    = COLS * ROWS;
  localparam int            c_cw   = $clog2(c_n);
  localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cells [c_n];
  logic [c_cw-1:0] r_cursor;
  logic [c_cw-1:0] r_clr_idx;
  logic            r_busy;

  logic r_next_s1, r_next_s2, r_next_d;
  logic r_prev_s1, r_prev_s2, r_prev_d;

  logic            w_next_step;
  logic            w_prev_step;
  logic [c_cw-1:0] w_cur_inc;
  logic [c_cw-1:0] w_cur_dec;

  // Button levels: two-flop synchronizer followed by an edge-detect stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_s1 <= 1'b0;
      r_next_s2 <= 1'b0;
      r_next_d  <= 1'b0;
      r_prev_s1 <= 1'b0;
      r_prev_s2 <= 1'b0;
      r_prev_d  <= 1'b0;
    end else begin
      r_next_s1 <= next_i;
      r_next_s2 <= r_next_s1;
      r_next_d  <= r_next_s2;
      r_prev_s1 <= prev_i;
      r_prev_s2 <= r_prev_s1;
      r_prev_d  <= r_prev_s2;
    end
  end

  assign w_next_step = r_next_s2 & ~r_next_d;
  assign w_prev_step = r_prev_s2 & ~r_prev_d;

  // Compare against the last index so that wrapping works for any N
  assign w_cur_inc = (r_cursor == c_last) ? '0 : r_cursor + 1'b1;
  assign w_cur_dec = (r_cursor == '0) ? c_last : r_cursor - 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cursor  <= '0;
      r_clr_idx <= '0;
      r_busy    <= 1'b0;
      for (int i = 0; i < c_n; i++) begin
        r_cells[i] <= BLANK;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr_i) begin
            r_state   <= S_CLEAR;
            r_busy    <= 1'b1;
            r_clr_idx <= '0;
          end else if (wr_i) begin
            r_cells[r_cursor] <= char_i;
            if (AUTO_ADV != 0) begin
              r_cursor <= w_cur_inc;
            end
          end else if (bksp_i) begin
            r_cursor           <= w_cur_dec;
            r_cells[w_cur_dec] <= BLANK;
          end else if (w_next_step && !w_prev_step) begin
            r_cursor <= w_cur_inc;
          end else if (w_prev_step && !w_next_step) begin
            r_cursor <= w_cur_dec;
          end
        end
        S_CLEAR: begin
          r_cells[r_clr_idx] <= BLANK;
          if (r_clr_idx == c_last) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_cursor <= '0;
          end else begin
            r_clr_idx <= r_clr_idx + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < c_n; i++) begin : g_flat
    assign symbols_o[8*(c_n-1-i) +: 8] = r_cells[i];
  end

  assign cursor_o = r_cursor;
  assign busy_o   = r_busy;

endmodule

`default_nettype wire
